// File: rtl/s7_iserdes_aligner_if.sv
// Bus between the word aligner and its ISERDES-side environment.
// master: the driving side (ISERDES outputs, control); slave: the aligner.
interface s7_iserdes_aligner_if #(
   parameter int unsigned N_CHANNELS = 2,
   parameter int unsigned DW         = 8
);
   localparam int unsigned SCW = $clog2(DW) + 1;

   logic                       start;
   logic [DW-1:0]              frame_word;
   logic [N_CHANNELS*DW-1:0]   data_words;
   logic                       bitslip;
   logic [N_CHANNELS*DW-1:0]   data_out;
   logic                       data_valid;
   logic                       locked;
   logic                       failed;
   logic [SCW-1:0]             slip_count;
   logic [7:0]                 relock_count;

   modport master (
      output start, frame_word, data_words,
      input  bitslip, data_out, data_valid, locked, failed, slip_count, relock_count
   );

   modport slave (
      input  start, frame_word, data_words,
      output bitslip, data_out, data_valid, locked, failed, slip_count, relock_count
   );
endinterface

// File: rtl/s7_iserdes_aligner.sv
// Word-alignment controller for 7-series ISERDES LVDS ADC capture.
// Pulses a common bitslip until the frame-clock word equals PATTERN, then forwards
// registered channel data with a valid flag. Optional macro ALIGN_MONITOR_EN adds
// loss-of-lock monitoring in LOCKED with automatic re-alignment.
module s7_iserdes_aligner #(
   parameter int unsigned   N_CHANNELS     = 2,
   parameter int unsigned   DW             = 8,
   parameter logic [DW-1:0] PATTERN        = 8'hF0,
   parameter int unsigned   SETTLE_CYCLES  = 16,
   parameter int unsigned   CHECK_CYCLES   = 4,
   parameter int unsigned   LOSS_THRESHOLD = 4
) (
   input logic                 sys_clk,
   input logic                 sys_rst_n,
   s7_iserdes_aligner_if.slave bus
);

   localparam int unsigned SCW = $clog2(DW) + 1;
   localparam int unsigned SW  = $clog2(SETTLE_CYCLES + 1);
   localparam int unsigned CW  = $clog2(CHECK_CYCLES + 1);

   localparam logic [SCW-1:0] SLIP_LAST   = SCW'(DW - 1);
   localparam logic [SW-1:0]  SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
   localparam logic [CW-1:0]  CHECK_LAST  = CW'(CHECK_CYCLES - 1);

   localparam logic [2:0] StIdle   = 3'd0;
   localparam logic [2:0] StSettle = 3'd1;
   localparam logic [2:0] StCheck  = 3'd2;
   localparam logic [2:0] StSlip   = 3'd3;
   localparam logic [2:0] StLocked = 3'd4;
   localparam logic [2:0] StFail   = 3'd5;

   logic [2:0]               state_q, state_d;
   logic [SW-1:0]            settle_cnt_q, settle_cnt_d;
   logic [CW-1:0]            match_cnt_q, match_cnt_d;
   logic [SCW-1:0]           slip_cnt_q, slip_cnt_d;
   logic                     bitslip_q, bitslip_d;
   logic                     locked_q, locked_d;
   logic                     failed_q, failed_d;
   logic [N_CHANNELS*DW-1:0] data_q;

   logic frame_match;
   assign frame_match = (bus.frame_word == PATTERN);

`ifdef ALIGN_MONITOR_EN
   localparam int unsigned     LW        = $clog2(LOSS_THRESHOLD + 1);
   localparam logic [LW-1:0]   LOSS_LAST = LW'(LOSS_THRESHOLD - 1);

   logic [LW-1:0] loss_cnt_q, loss_cnt_d;
   logic [7:0]    relock_cnt_q, relock_cnt_d;
`else
   // The threshold only matters to the monitor; keep it referenced in this build.
   logic [31:0] unused_loss_threshold;
   assign unused_loss_threshold = LOSS_THRESHOLD;
`endif

   // Next-state and counter updates for the alignment FSM.
   always_comb begin
      state_d      = state_q;
      settle_cnt_d = settle_cnt_q;
      match_cnt_d  = match_cnt_q;
      slip_cnt_d   = slip_cnt_q;
      bitslip_d    = 1'b0;
      locked_d     = locked_q;
      failed_d     = failed_q;
`ifdef ALIGN_MONITOR_EN
      loss_cnt_d   = loss_cnt_q;
      relock_cnt_d = relock_cnt_q;
`endif
      case (state_q)
         StIdle, StFail: begin
            if (bus.start) begin
               state_d      = StSettle;
               settle_cnt_d = '0;
               slip_cnt_d   = '0;
               failed_d     = 1'b0;
            end
         end
         StSettle: begin
            if (settle_cnt_q == SETTLE_LAST) begin
               state_d     = StCheck;
               match_cnt_d = '0;
            end else begin
               settle_cnt_d = settle_cnt_q + 1'b1;
            end
         end
         StCheck: begin
            if (frame_match) begin
               if (match_cnt_q == CHECK_LAST) begin
                  state_d  = StLocked;
                  locked_d = 1'b1;
`ifdef ALIGN_MONITOR_EN
                  loss_cnt_d = '0;
`endif
               end else begin
                  match_cnt_d = match_cnt_q + 1'b1;
               end
            end else if (slip_cnt_q == SLIP_LAST) begin
               // Every rotation has been tried without a match.
               state_d  = StFail;
               failed_d = 1'b1;
            end else begin
               state_d   = StSlip;
               bitslip_d = 1'b1;
            end
         end
         StSlip: begin
            state_d      = StSettle;
            settle_cnt_d = '0;
            slip_cnt_d   = slip_cnt_q + 1'b1;
         end
         StLocked: begin
            if (bus.start) begin
               state_d      = StSettle;
               settle_cnt_d = '0;
               slip_cnt_d   = '0;
               locked_d     = 1'b0;
            end
`ifdef ALIGN_MONITOR_EN
            else if (frame_match) begin
               loss_cnt_d = '0;
            end else if (loss_cnt_q == LOSS_LAST) begin
               state_d      = StSettle;
               settle_cnt_d = '0;
               slip_cnt_d   = '0;
               locked_d     = 1'b0;
               loss_cnt_d   = '0;
               if (relock_cnt_q != 8'hFF) begin
                  relock_cnt_d = relock_cnt_q + 1'b1;
               end
            end else begin
               loss_cnt_d = loss_cnt_q + 1'b1;
            end
`endif
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // FSM state, counters and status flags.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q      <= StIdle;
         settle_cnt_q <= '0;
         match_cnt_q  <= '0;
         slip_cnt_q   <= '0;
         bitslip_q    <= 1'b0;
         locked_q     <= 1'b0;
         failed_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         settle_cnt_q <= settle_cnt_d;
         match_cnt_q  <= match_cnt_d;
         slip_cnt_q   <= slip_cnt_d;
         bitslip_q    <= bitslip_d;
         locked_q     <= locked_d;
         failed_q     <= failed_d;
      end
   end

`ifdef ALIGN_MONITOR_EN
   // Loss-of-lock run length and saturating re-alignment count.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         loss_cnt_q   <= '0;
         relock_cnt_q <= '0;
      end else begin
         loss_cnt_q   <= loss_cnt_d;
         relock_cnt_q <= relock_cnt_d;
      end
   end

   assign bus.relock_count = relock_cnt_q;
`else
   assign bus.relock_count = 8'd0;
`endif

   // Data pipeline: one-cycle registered copy, independent of alignment state.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         data_q <= '0;
      end else begin
         data_q <= bus.data_words;
      end
   end

   assign bus.bitslip    = bitslip_q;
   assign bus.data_out   = data_q;
   // locked_q updates on the same edge as data_q, so both describe the same sample.
   assign bus.data_valid = locked_q;
   assign bus.locked     = locked_q;
   assign bus.failed     = failed_q;
   assign bus.slip_count = slip_cnt_q;

endmodule

// File: tb/tb_s7_iserdes_aligner.sv
// Directed bench for s7_iserdes_aligner with a simple ISERDES frame-word model.
module tb_s7_iserdes_aligner;

   localparam int unsigned S = 16;
   localparam int unsigned C = 4;

   logic sys_clk;
   logic sys_rst_n;

   s7_iserdes_aligner_if #(.N_CHANNELS(2), .DW(8)) bus ();

   s7_iserdes_aligner #(
      .N_CHANNELS     (2),
      .DW             (8),
      .PATTERN        (8'hF0),
      .SETTLE_CYCLES  (S),
      .CHECK_CYCLES   (C),
      .LOSS_THRESHOLD (4)
   ) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .bus       (bus)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   // Frame model: loads 8'h87; each bitslip steps the rotation so three slips reach 8'hF0.
   logic       model_load;
   logic       use_model;
   logic [7:0] model_word;
   logic [7:0] frame_const;

   always @(posedge sys_clk) begin
      if (model_load) model_word <= 8'h87;
      else if (bus.bitslip) model_word <= {model_word[0], model_word[7:1]};
   end

   assign bus.frame_word = use_model ? model_word : frame_const;

   int vectors;
   int miscompares;
   int cyc;
   int pulses;
   int min_gap;
   int last_slip;
   int done_cyc;
   int start_cyc;
   int first_start;
   int drops;
   logic timed_out;

   function automatic void check(input string tag, input logic [31:0] obs,
                                 input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
      end
   endfunction

   task automatic step();
      @(posedge sys_clk);
      #1;
      cyc++;
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      step();
      start_cyc = cyc;
      bus.start = 1'b0;
   endtask

   // Runs until locked (or failed), counting bitslip pulses and their spacing.
   task automatic run_until(input logic want_fail, input int limit);
      int prev;
      int n;
      prev      = -1000;
      pulses    = 0;
      min_gap   = 1000;
      timed_out = 1'b1;
      n         = 0;
      while (timed_out && n < limit) begin
         step();
         n++;
         if (bus.bitslip) begin
            pulses++;
            if (cyc - prev < min_gap) min_gap = cyc - prev;
            prev      = cyc;
            last_slip = cyc;
         end
         if (want_fail ? bus.failed : bus.locked) begin
            timed_out = 1'b0;
            done_cyc  = cyc;
         end
      end
      check("wait_timeout", {31'd0, timed_out}, 32'd0);
   endtask

   initial begin
      vectors        = 0;
      miscompares    = 0;
      cyc            = 0;
      last_slip      = 0;
      done_cyc       = 0;
      sys_rst_n      = 1'b0;
      bus.start      = 1'b0;
      bus.data_words = 16'h0000;
      model_load     = 1'b1;
      use_model      = 1'b1;
      frame_const    = 8'h00;

      // Reset state.
      step();
      step();
      check("rst_bitslip", {31'd0, bus.bitslip}, 32'd0);
      check("rst_locked", {31'd0, bus.locked}, 32'd0);
      check("rst_failed", {31'd0, bus.failed}, 32'd0);
      check("rst_valid", {31'd0, bus.data_valid}, 32'd0);
      check("rst_slip_count", {28'd0, bus.slip_count}, 32'd0);
      check("rst_data_out", {16'd0, bus.data_out}, 32'd0);
      check("rst_relock", {24'd0, bus.relock_count}, 32'd0);
      sys_rst_n = 1'b1;
      step();
      model_load = 1'b0;
      step();

      // Alignment from 8'h87: three slips, then lock S+C cycles after the last SETTLE entry.
      pulse_start();
      run_until(1'b0, 400);
      check("a_pulses", pulses, 3);
      check("a_locked", {31'd0, bus.locked}, 32'd1);
      check("a_slip_count", {28'd0, bus.slip_count}, 32'd3);
      check("a_failed", {31'd0, bus.failed}, 32'd0);
      check("a_valid", {31'd0, bus.data_valid}, 32'd1);
      // SETTLE is entered one cycle after the bitslip cycle.
      check("a_lock_delay", done_cyc - last_slip, S + C + 1);
      check("a_min_gap_ok", {31'd0, min_gap >= S + 2}, 32'd1);

      // Locked data forwarding, one cycle latency.
      bus.data_words = 16'hA55A;
      step();
      check("d_out_a55a", {16'd0, bus.data_out}, 32'h0000A55A);
      check("d_valid", {31'd0, bus.data_valid}, 32'd1);
      bus.data_words = 16'h1234;
      step();
      check("d_out_1234", {16'd0, bus.data_out}, 32'h00001234);

      // Restart from LOCKED; a start during SETTLE must not restart the sequence.
      pulse_start();
      first_start = start_cyc;
      check("r_valid_drop", {31'd0, bus.data_valid}, 32'd0);
      check("r_locked_drop", {31'd0, bus.locked}, 32'd0);
      check("r_slip_clear", {28'd0, bus.slip_count}, 32'd0);
      step();
      step();
      step();
      pulse_start();
      run_until(1'b0, 400);
      check("r_pulses", pulses, 0);
      check("r_lock_delay", done_cyc - first_start, S + C);

      // Constant 8'h00 frame: seven slips then FAIL.
      use_model   = 1'b0;
      frame_const = 8'h00;
      pulse_start();
      run_until(1'b1, 600);
      check("f_pulses", pulses, 7);
      check("f_failed", {31'd0, bus.failed}, 32'd1);
      check("f_locked", {31'd0, bus.locked}, 32'd0);
      check("f_slip_count", {28'd0, bus.slip_count}, 32'd7);
      check("f_min_gap_ok", {31'd0, min_gap >= S + 2}, 32'd1);
      pulses = 0;
      for (int i = 0; i < 30; i++) begin
         step();
         if (bus.bitslip) pulses++;
      end
      check("f_idle_pulses", pulses, 0);
      check("f_hold_slip", {28'd0, bus.slip_count}, 32'd7);
      check("f_hold_failed", {31'd0, bus.failed}, 32'd1);

      // Second start clears failed and repeats.
      pulse_start();
      check("f2_failed_clr", {31'd0, bus.failed}, 32'd0);
      check("f2_slip_clr", {28'd0, bus.slip_count}, 32'd0);
      run_until(1'b1, 600);
      check("f2_pulses", pulses, 7);
      check("f2_failed", {31'd0, bus.failed}, 32'd1);

      // Re-lock from 8'h87 before the loss tests.
      model_load = 1'b1;
      use_model  = 1'b1;
      step();
      model_load = 1'b0;
      pulse_start();
      run_until(1'b0, 400);
      check("b_pulses", pulses, 3);
      check("b_slip_count", {28'd0, bus.slip_count}, 32'd3);

`ifdef ALIGN_MONITOR_EN
      // Three mismatches are tolerated.
      use_model = 1'b0;
      step();
      step();
      step();
      use_model = 1'b1;
      step();
      check("m3_locked", {31'd0, bus.locked}, 32'd1);
      check("m3_relock", {24'd0, bus.relock_count}, 32'd0);
      // Four mismatches drop lock and start re-alignment.
      use_model = 1'b0;
      step();
      step();
      step();
      check("m4_still_locked", {31'd0, bus.locked}, 32'd1);
      step();
      check("m4_locked", {31'd0, bus.locked}, 32'd0);
      check("m4_valid", {31'd0, bus.data_valid}, 32'd0);
      check("m4_relock", {24'd0, bus.relock_count}, 32'd1);
      check("m4_slip_clr", {28'd0, bus.slip_count}, 32'd0);
      use_model = 1'b1;
      run_until(1'b0, 400);
      check("m4_relocked", {31'd0, bus.locked}, 32'd1);
      check("m4_relock_hold", {24'd0, bus.relock_count}, 32'd1);
`else
      // frame_word is ignored while locked.
      use_model = 1'b0;
      drops     = 0;
      pulses    = 0;
      for (int i = 0; i < 100; i++) begin
         step();
         if (!bus.locked) drops++;
         if (bus.bitslip) pulses++;
      end
      check("n_drops", drops, 0);
      check("n_pulses", pulses, 0);
      check("n_locked", {31'd0, bus.locked}, 32'd1);
      check("n_relock", {24'd0, bus.relock_count}, 32'd0);
      use_model = 1'b1;
`endif

      // Asynchronous reset mid-SETTLE after two slips.
      model_load = 1'b1;
      step();
      model_load     = 1'b0;
      bus.data_words = 16'hA55A;
      pulse_start();
      pulses = 0;
      drops  = 0;
      while (pulses < 2 && drops < 200) begin
         step();
         drops++;
         if (bus.bitslip) pulses++;
      end
      check("x_two_slips", pulses, 2);
      step();
      step();
      step();
      check("x_pre_slip", {28'd0, bus.slip_count}, 32'd2);
      check("x_pre_data", {16'd0, bus.data_out}, 32'h0000A55A);
      #2;
      sys_rst_n = 1'b0;
      #1;
      check("x_slip_count", {28'd0, bus.slip_count}, 32'd0);
      check("x_data_out", {16'd0, bus.data_out}, 32'd0);
      check("x_locked", {31'd0, bus.locked}, 32'd0);
      check("x_failed", {31'd0, bus.failed}, 32'd0);
      check("x_bitslip", {31'd0, bus.bitslip}, 32'd0);
      step();
      sys_rst_n = 1'b1;
      pulses    = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (bus.bitslip) pulses++;
      end
      check("x_no_slip", pulses, 0);
      check("x_idle_locked", {31'd0, bus.locked}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
